// File: rtl/mdu_pkg.sv
// Shared multiply/divide definitions: op encodings, FSM states, funct decode.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    // R-type funct codes the control unit routes to this block
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    function automatic logic is_mdu_funct(input logic [5:0] funct);
        return funct[5:2] == FUNCT_MULT[5:2];
    endfunction

    // The low two funct bits line up with the op encoding
    function automatic mdu_op_e funct_to_op(input logic [5:0] funct);
        return mdu_op_e'(funct[1:0]);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Control-unit <-> multiply/divide handshake and result bundle.
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mdu_step.sv
// One iteration of shift-add multiply or restoring shift-subtract divide.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff   = rem_sh - {1'b0, operand};
        acc_next = {sum, acc[WIDTH-1:1]};
        if (is_div) begin
            // Top of diff is the borrow: set means the trial subtract is undone
            if (!diff[WIDTH]) begin
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply and divide producing HI/LO.
// Latency: WIDTH+2 cycles from accepted start to done; 1 cycle for divide-by-zero.
// Backpressure: start is only accepted in IDLE/DONE; busy marks the ignored window.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    mult_div_unit_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mdu_state_e         state_q, state_d;
    mdu_op_e            op_q;
    logic [WIDTH-1:0]   mag_b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [WIDTH-1:0]   fix_hi, fix_lo;
    logic               div_zero_q;
    logic               busy, done;
    logic               accept, req_div, req_signed, zero_div, last_step, op_is_div;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    assign accept     = bus.start && (state_q == IDLE || state_q == DONE);
    assign req_div    = bus.op[1];
    assign req_signed = ~bus.op[0];
    assign zero_div   = req_div && (bus.b == '0);
    assign last_step  = cnt_q == CNT_W'(WIDTH - 1);
    assign op_is_div  = (op_q == MDU_DIV) || (op_q == MDU_DIVU);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                done    = (state_q == DONE);
                state_d = IDLE;
                if (bus.start) begin
                    state_d = zero_div ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_step) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (op_is_div),
        .acc      (acc_q),
        .operand  (mag_b_q),
        .acc_next (acc_step)
    );

    // Remainder follows the dividend sign; quotient/product follow the sign xor
    always_comb begin
        prod_fix = neg_res_q ? -acc_q : acc_q;
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (op_is_div) begin
            fix_hi = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            fix_lo = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= MDU_MULT;
            mag_b_q    <= '0;
            acc_q      <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else if (accept) begin
            op_q       <= mdu_op_e'(bus.op);
            mag_b_q    <= mag(bus.b, req_signed);
            acc_q      <= {{WIDTH{1'b0}}, mag(bus.a, req_signed)};
            neg_res_q  <= req_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_rem_q  <= req_signed && bus.a[WIDTH-1];
            cnt_q      <= '0;
            div_zero_q <= zero_div;
        end else if (state_q == CALC) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + 1'b1;
        end else if (state_q == FIX) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit at WIDTH=32 and WIDTH=8.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   lat;

    mult_div_unit_if #(.WIDTH(32)) m32();
    mult_div_unit_if #(.WIDTH(8))  m8();

    mult_div_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(m32));
    mult_div_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(m8));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge after the accepting edge
    task automatic launch32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        m32.start = 1'b1;
        m32.op    = op;
        m32.a     = a;
        m32.b     = b;
        @(negedge clk);
        m32.start = 1'b0;
    endtask

    task automatic launch8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        m8.start = 1'b1;
        m8.op    = op;
        m8.a     = a;
        m8.b     = b;
        @(negedge clk);
        m8.start = 1'b0;
    endtask

    // l counts cycles since the accepting edge; poke>0 pulses a stray start then
    task automatic wait32(input int poke, output int l);
        l = 1;
        while (m32.done !== 1'b1 && l < 100) begin
            if (l == poke) begin
                m32.start = 1'b1;
                m32.op    = 2'd3;
                m32.a     = 32'd99;
                m32.b     = 32'd0;
            end else begin
                m32.start = 1'b0;
            end
            @(negedge clk);
            l++;
        end
        m32.start = 1'b0;
    endtask

    task automatic wait8(output int l);
        l = 1;
        while (m8.done !== 1'b1 && l < 100) begin
            @(negedge clk);
            l++;
        end
    endtask

    initial begin
        reset = 1'b1;
        m32.start = 1'b0; m32.op = 2'd0; m32.a = '0; m32.b = '0;
        m8.start  = 1'b0; m8.op  = 2'd0; m8.a  = '0; m8.b  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy_done_dz", {61'd0, m32.busy, m32.done, m32.div_zero}, 64'd0);
        chk("rst_hilo", {m32.hi, m32.lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy_done", {62'd0, m32.busy, m32.done}, 64'd0);

        // MULT -3 * 5
        launch32(MDU_MULT, 32'hFFFF_FFFD, 32'd5);
        chk("mult_busy_rise", {63'd0, m32.busy}, 64'd1);
        wait32(0, lat);
        chk("mult_latency", lat, 34);
        chk("mult_neg", {m32.hi, m32.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        chk("mult_done_busy_dz", {62'd0, m32.busy, m32.div_zero}, 64'd0);
        @(negedge clk);
        chk("mult_done_pulse", {63'd0, m32.done}, 64'd0);

        launch32(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait32(0, lat);
        chk("multu_latency", lat, 34);
        chk("multu_max", {m32.hi, m32.lo}, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk);

        launch32(MDU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait32(0, lat);
        chk("mult_m1_m1", {m32.hi, m32.lo}, 64'h0000_0000_0000_0001);
        @(negedge clk);

        launch32(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        wait32(0, lat);
        chk("div_latency", lat, 34);
        chk("div_m7_2", {m32.hi, m32.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        @(negedge clk);

        // DIVU 7/2, then DIV 7/-2 requested back-to-back during DONE
        launch32(MDU_DIVU, 32'd7, 32'd2);
        wait32(0, lat);
        chk("divu_7_2", {m32.hi, m32.lo}, 64'h0000_0001_0000_0003);
        launch32(MDU_DIV, 32'd7, 32'hFFFF_FFFE);
        chk("b2b_done_busy", {62'd0, m32.done, m32.busy}, 64'd1);
        chk("b2b_hold_hilo", {m32.hi, m32.lo}, 64'h0000_0001_0000_0003);
        wait32(0, lat);
        chk("b2b_latency", lat, 34);
        chk("div_7_m2", {m32.hi, m32.lo}, 64'h0000_0001_FFFF_FFFD);
        @(negedge clk);

        launch32(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait32(0, lat);
        chk("div_min_m1", {m32.hi, m32.lo}, 64'h0000_0000_8000_0000);
        chk("div_min_m1_dz", {63'd0, m32.div_zero}, 64'd0);
        @(negedge clk);

        // DIVU by zero: one-cycle turnaround, result registers untouched
        launch32(MDU_DIVU, 32'd1234, 32'd0);
        chk("dz_done_dz_busy", {61'd0, m32.done, m32.div_zero, m32.busy}, 64'd6);
        chk("dz_hold_hilo", {m32.hi, m32.lo}, 64'h0000_0000_8000_0000);
        @(negedge clk);
        chk("dz_done_dz_after", {62'd0, m32.done, m32.div_zero}, 64'd1);

        // Stray start mid-CALC (with a divide-by-zero payload) must be ignored
        launch32(MDU_MULTU, 32'd6, 32'd7);
        wait32(5, lat);
        chk("poke_latency", lat, 34);
        chk("poke_result", {m32.hi, m32.lo}, 64'd42);
        chk("poke_dz_cleared", {63'd0, m32.div_zero}, 64'd0);
        @(negedge clk);

        // Reset in the tenth CALC cycle
        launch32(MDU_DIVU, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        chk("pre_reset_busy", {63'd0, m32.busy}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_reset_flags", {61'd0, m32.busy, m32.done, m32.div_zero}, 64'd0);
        chk("mid_reset_hilo", {m32.hi, m32.lo}, 64'd0);

        launch32(MDU_DIV, 32'hFFFF_FF9C, 32'd7);
        wait32(0, lat);
        chk("fresh_latency", lat, 34);
        chk("fresh_div_m100_7", {m32.hi, m32.lo}, 64'hFFFF_FFFE_FFFF_FFF2);
        @(negedge clk);

        // WIDTH=8 instance
        launch8(MDU_MULT, 8'h80, 8'h80);
        wait8(lat);
        chk("w8_mult_latency", lat, 10);
        chk("w8_mult_min_min", {48'd0, m8.hi, m8.lo}, 64'h4000);
        @(negedge clk);

        launch8(MDU_DIV, 8'h80, 8'hFF);
        wait8(lat);
        chk("w8_div_min_m1", {48'd0, m8.hi, m8.lo}, 64'h0080);
        chk("w8_div_dz", {63'd0, m8.div_zero}, 64'd0);
        @(negedge clk);

        launch8(MDU_DIV, 8'hF9, 8'h03);
        wait8(lat);
        chk("w8_div_m7_3", {48'd0, m8.hi, m8.lo}, 64'hFFFE);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit that produces the HI/LO result pair for the multicycle CPU datapath. It replaces the fixed 32-bit arrangement with a WIDTH-parametrised engine supporting signed and unsigned multiply and divide. It runs a start/busy/done handshake with the control unit and flags divide-by-zero for the exception path to EPC. Results feed the HI and LO registers; the block holds them until the next completion.

## Interface
- WIDTH, 32: operand width; hi and lo are each WIDTH bits; must be even and ≥4
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE or DONE
- op  in  2  0=MULT (signed), 1=MULTU, 2=DIV (signed), 3=DIVU
- a  in  WIDTH  multiplicand / dividend (from A register)
- b  in  WIDTH  multiplier / divisor (from B register)
- busy  out  1  high in CALC and FIX
- done  out  1  one-cycle pulse; hi/lo and div_zero valid
- div_zero  out  1  valid with done; high if op is DIV/DIVU and b==0
- hi  out  WIDTH  product high half / remainder
- lo  out  WIDTH  product low half / quotient

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE with start=1:
  - Latch op, |a|, |b| (magnitudes only for signed ops), and result signs.
  - Clear the step counter.
  - If the op is a divide and b==0, go to DONE with div_zero=1; hi/lo unchanged.
  - Otherwise go to CALC.
- IDLE/DONE with start=0: DONE→IDLE; IDLE stays.
- CALC: one bit per cycle for exactly WIDTH cycles.
  - Multiply: shift-add on magnitudes into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract; one quotient bit per cycle.
  - After the last step go to FIX.
- FIX (1 cycle): apply sign correction.
  - Signed product: negate the 2·WIDTH result if the operand signs differ.
  - Signed quotient: negate if the signs differ.
  - Remainder takes the sign of the dividend.
  - Write hi/lo, then go to DONE.
- DONE: done=1 for this cycle only.
- Arithmetic:
  - MULT/MULTU: {hi,lo} = full 2·WIDTH product.
  - DIV/DIVU: lo = quotient truncated toward zero; hi = remainder.
  - Signed DIV of MIN by -1: lo = MIN, hi = 0, no flag.
- start in CALC/FIX is ignored; a/b/op changes after acceptance have no effect.
- div_zero is cleared on the next accepted start or on reset.

## Timing
- Reset values: state IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; counter 0.
- Start accepted at edge E0 (normal op):
  - busy rises after E0.
  - CALC occupies the cycles after E0 through E(WIDTH).
  - FIX is the cycle after E(WIDTH).
  - hi/lo update at E(WIDTH+1).
  - done is high in the cycle after E(WIDTH+1), i.e. WIDTH+2 cycles after start is sampled.
- Divide-by-zero: done and div_zero are high in the cycle after E0 (latency 1); busy never rises.
- Back-to-back: start held high during DONE is accepted at that edge.
  - The done pulse still lasts exactly one cycle.
  - hi/lo keep the previous result until the new FIX edge.
- Reset during any state: all outputs return to reset values at the next edge; the operation is abandoned.
- hi/lo are registered outputs: no combinational path from a, b or op.

## Structure
- Shared package mdu_pkg:
  - op encodings MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU;
  - state enum (IDLE, CALC, FIX, DONE);
  - control-unit decode constants for funct → op.
- Sub-module mdu_step (combinational, WIDTH-parametrised):
  - one shift-add / shift-subtract step;
  - instantiated once, selected by op class.
- Counter width is $clog2(WIDTH+1).

## Test plan
- MULT, a=0xFFFFFFFD (-3), b=5 → after 34 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU, a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- MULT, a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0, lo=1.
- DIV, a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU, a=7, b=2 → lo=3, hi=1.
- DIV, a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, div_zero=0.
- DIVU, b=0 → done and div_zero high one cycle after start; hi/lo hold the prior result; busy stays 0.
- Control and reset:
  - start pulsed mid-CALC is ignored; the original result arrives on schedule.
  - reset asserted at cycle 10 of CALC → next cycle busy=0, done=0, hi=lo=0.
  - A fresh start then completes normally.
- WIDTH=8 instance:
  - MULT 0x80×0x80 → {hi,lo}=0x4000 after 10 cycles.
  - DIV 0x80/0xFF → lo=0x80, hi=0.
